// File: rtl/note_envelope.sv
// -----------------------------------------------------------------------------
// note_envelope
//   Per-voice ADSR volume envelope. A note-on pulse registers the instrument
//   index onto the ROM address port; one clock later the LOAD state latches
//   the envelope word (attack/decay/release rates and sustain level). The
//   4-bit volume then walks attack -> decay -> sustain, and release on
//   note-off, stepping once per (rate+1) envelope strobes.
//
// Ports
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_env_stb       envelope tick strobe (1-cycle pulse)
//   i_note_on       (re)trigger pulse; volume is not cleared on retrigger
//   i_note_off      release pulse
//   i_instrument    instrument index, sampled with i_note_on
//   o_inst_addr     registered instrument ROM address
//   i_inst_data     ROM word: [3:0] A, [7:4] D, [11:8] S, [15:12] R
//   o_volume        current envelope volume, 0..15
//   o_active        high whenever the envelope is not IDLE
// -----------------------------------------------------------------------------
module note_envelope #(
    parameter int INST_W = 4,
    parameter int RATE_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_env_stb,
    input  logic              i_note_on,
    input  logic              i_note_off,
    input  logic [INST_W-1:0] i_instrument,
    output logic [INST_W-1:0] o_inst_addr,
    input  logic [15:0]       i_inst_data,
    output logic [3:0]        o_volume,
    output logic              o_active
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ATTACK,
        ST_DECAY,
        ST_SUSTAIN,
        ST_RELEASE
    } state_e;

    state_e            state_q, state_d;
    logic [INST_W-1:0] addr_q, addr_d;
    logic [3:0]        vol_q, vol_d;
    logic [RATE_W-1:0] tick_q, tick_d;
    logic [RATE_W-1:0] atk_q, atk_d;
    logic [RATE_W-1:0] dec_q, dec_d;
    logic [RATE_W-1:0] rel_q, rel_d;
    logic [3:0]        sus_q, sus_d;
    logic              active_q;
    logic [RATE_W-1:0] rate_sel;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; combinational blocks below use blocking (=).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: note_on beats note_off, which beats the normal flow.
    // -------------------------------------------------------------------------
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (i_note_on) begin
            state_d = ST_LOAD;
        end else if (i_note_off &&
                     (state_q inside {ST_LOAD, ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
            state_d = ST_RELEASE;
        end else begin
            case (state_q)
                ST_LOAD:    state_d = ST_ATTACK;
                ST_ATTACK:  if (vol_q == 4'd15) state_d = ST_DECAY;
                ST_DECAY:   if (vol_q <= sus_q) state_d = ST_SUSTAIN;
                ST_RELEASE: if (vol_q == 4'd0)  state_d = ST_IDLE;
                default:    state_d = state_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output / datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        addr_d   = addr_q;
        vol_d    = vol_q;
        tick_d   = tick_q;
        atk_d    = atk_q;
        dec_d    = dec_q;
        rel_d    = rel_q;
        sus_d    = sus_q;

        case (state_q)
            ST_ATTACK:  rate_sel = atk_q;
            ST_DECAY:   rate_sel = dec_q;
            ST_RELEASE: rate_sel = rel_q;
            default:    rate_sel = '0;
        endcase

        if (i_note_on) begin
            addr_d = i_instrument;
        end

        // The ROM word is valid during LOAD (address was registered on entry).
        if (state_q == ST_LOAD) begin
            atk_d = i_inst_data[0  +: RATE_W];
            dec_d = i_inst_data[4  +: RATE_W];
            sus_d = i_inst_data[11:8];
            rel_d = i_inst_data[12 +: RATE_W];
        end

        // Any transition (including LOAD->LOAD retrigger) restarts the tick
        // count and swallows a coincident strobe. Volume range is guarded by
        // the state checks, so the +1/-1 below can never wrap.
        if (i_note_on || (state_d != state_q)) begin
            tick_d = '0;
        end else if (i_env_stb &&
                     (state_q inside {ST_ATTACK, ST_DECAY, ST_RELEASE})) begin
            if (tick_q == rate_sel) begin
                tick_d = '0;
                vol_d  = (state_q == ST_ATTACK) ? vol_q + 4'd1 : vol_q - 4'd1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q   <= '0;
            vol_q    <= '0;
            tick_q   <= '0;
            atk_q    <= '0;
            dec_q    <= '0;
            rel_q    <= '0;
            sus_q    <= '0;
            active_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            vol_q    <= vol_d;
            tick_q   <= tick_d;
            atk_q    <= atk_d;
            dec_q    <= dec_d;
            rel_q    <= rel_d;
            sus_q    <= sus_d;
            active_q <= (state_d != ST_IDLE);
        end
    end

    assign o_inst_addr = addr_q;
    assign o_volume    = vol_q;
    assign o_active    = active_q;

endmodule

// File: tb/tb_note_envelope.sv
// -----------------------------------------------------------------------------
// tb_note_envelope
//   Self-checking bench for note_envelope. A vector table of per-cycle inputs
//   and expected post-edge outputs is built up front; each applied vector
//   pushes its expectation onto a scoreboard queue, and a monitor pops and
//   compares one entry just after every rising edge. The asynchronous reset
//   case is a hand-written sequence with immediate checks.
//   The instrument ROM is the registered o_inst_addr feeding an array read,
//   so its word is valid one clock after the address changes.
// -----------------------------------------------------------------------------
module tb_note_envelope;

    typedef struct {
        logic       on;
        logic       off;
        logic       stb;
        logic [3:0] inst;
        logic [3:0] vol;
        logic       act;
        logic [3:0] addr;
    } vec_t;

    typedef struct {
        logic [3:0] vol;
        logic       act;
        logic [3:0] addr;
        int         idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        env_stb;
    logic        note_on;
    logic        note_off;
    logic [3:0]  instrument;
    logic [3:0]  inst_addr;
    logic [15:0] inst_data;
    logic [3:0]  volume;
    logic        active;

    logic [15:0] rom [16];

    vec_t vecs[$];
    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_step = 0;

    note_envelope #(.INST_W(4), .RATE_W(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_env_stb    (env_stb),
        .i_note_on    (note_on),
        .i_note_off   (note_off),
        .i_instrument (instrument),
        .o_inst_addr  (inst_addr),
        .i_inst_data  (inst_data),
        .o_volume     (volume),
        .o_active     (active)
    );

    always #5 clk = ~clk;

    assign inst_data = rom[inst_addr];

    task automatic check(input string name, input int idx,
                         input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", name, idx, got, want);
        end
    endtask

    function automatic vec_t mk(input int on, input int off, input int stb, input int inst,
                                input int vol, input int act, input int addr);
        vec_t v;
        v.on   = 1'(on);
        v.off  = 1'(off);
        v.stb  = 1'(stb);
        v.inst = 4'(inst);
        v.vol  = 4'(vol);
        v.act  = 1'(act);
        v.addr = 4'(addr);
        return v;
    endfunction

    function automatic void add(input int on, input int off, input int stb, input int inst,
                                input int vol, input int act, input int addr);
        vecs.push_back(mk(on, off, stb, inst, vol, act, addr));
    endfunction

    // Drive one cycle of inputs on the falling edge and queue what the DUT
    // must show after the following rising edge.
    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        note_on    = v.on;
        note_off   = v.off;
        env_stb    = v.stb;
        instrument = v.inst;
        e.vol  = v.vol;
        e.act  = v.act;
        e.addr = v.addr;
        e.idx  = n_step;
        n_step++;
        sb_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("volume", mon_e.idx, 8'(volume),    8'(mon_e.vol));
            check("active", mon_e.idx, 8'(active),    8'(mon_e.act));
            check("addr",   mon_e.idx, 8'(inst_addr), 8'(mon_e.addr));
        end
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------------------------------------------------------
        // ROM contents
        //   3: A=0 D=1 S=10 R=2     5: A=0 D=0 S=15 R=0
        //   9: A=3 D=0 S=15 R=0
        // ---------------------------------------------------------------
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
        rom[3] = 16'h2A10;
        rom[5] = 16'h0F00;
        rom[9] = 16'h0F03;

        // ---------------------------------------------------------------
        // Vector table: on, off, stb, inst -> volume, active, addr
        // ---------------------------------------------------------------
        // Events in IDLE are ignored.
        add(0, 1, 0, 0,  0, 0, 0);
        add(0, 0, 1, 0,  0, 0, 0);
        // Simultaneous on+off in IDLE -> LOAD; full ADSR on instrument 3.
        add(1, 1, 0, 3,  0, 1, 3);
        add(0, 0, 1, 0,  0, 1, 3);                 // LOAD->ATTACK, strobe consumed
        for (int k = 1; k <= 15; k++) add(0, 0, 1, 0, k, 1, 3);
        add(0, 0, 1, 0, 15, 1, 3);                 // ATTACK->DECAY
        for (int j = 1; j <= 5; j++) begin         // one step per 2 strobes
            add(0, 0, 1, 0, 16 - j, 1, 3);
            add(0, 0, 1, 0, 15 - j, 1, 3);
        end
        add(0, 0, 1, 0, 10, 1, 3);                 // DECAY->SUSTAIN
        repeat (3) add(0, 0, 1, 0, 10, 1, 3);
        repeat (2) add(0, 0, 0, 0, 10, 1, 3);
        add(0, 1, 0, 0, 10, 1, 3);                 // SUSTAIN->RELEASE
        for (int j = 1; j <= 10; j++) begin        // one step per 3 strobes
            add(0, 0, 1, 0, 11 - j, 1, 3);
            add(0, 0, 1, 0, 11 - j, 1, 3);
            add(0, 0, 1, 0, 10 - j, 1, 3);
        end
        add(0, 0, 1, 0,  0, 0, 3);                 // RELEASE->IDLE
        add(0, 0, 1, 0,  0, 0, 3);
        // Instrument 5, S=15: ATTACK->DECAY->SUSTAIN holding 15.
        add(1, 0, 0, 5,  0, 1, 5);
        add(0, 0, 1, 0,  0, 1, 5);
        for (int k = 1; k <= 15; k++) add(0, 0, 1, 0, k, 1, 5);
        repeat (4) add(0, 0, 1, 0, 15, 1, 5);
        // Simultaneous on+off+strobe in SUSTAIN -> LOAD, volume held.
        add(1, 1, 1, 3, 15, 1, 3);
        add(0, 0, 1, 0, 15, 1, 3);                 // LOAD->ATTACK (rates of 3)
        add(0, 0, 1, 0, 15, 1, 3);                 // ATTACK->DECAY
        add(0, 1, 0, 0, 15, 1, 3);                 // DECAY->RELEASE
        for (int j = 1; j <= 9; j++) begin         // 15 -> 6
            add(0, 0, 1, 0, 16 - j, 1, 3);
            add(0, 0, 1, 0, 16 - j, 1, 3);
            add(0, 0, 1, 0, 15 - j, 1, 3);
        end
        add(0, 0, 1, 0,  6, 1, 3);                 // mid-count in RELEASE
        // Retrigger at volume 6 with instrument 9 (A=3): resumes from 6, and
        // the strobe in the LOAD cycle must not be counted.
        add(1, 0, 0, 9,  6, 1, 9);
        add(0, 0, 1, 0,  6, 1, 9);
        add(0, 0, 0, 0,  6, 1, 9);
        for (int j = 1; j <= 9; j++) begin         // one step per 4 strobes
            repeat (3) add(0, 0, 1, 0, 5 + j, 1, 9);
            add(0, 0, 1, 0, 6 + j, 1, 9);
        end
        repeat (3) add(0, 0, 1, 0, 15, 1, 9);
        add(0, 1, 0, 0, 15, 1, 9);
        for (int j = 1; j <= 15; j++) add(0, 0, 1, 0, 15 - j, 1, 9);
        add(0, 0, 1, 0,  0, 0, 9);
        add(0, 1, 0, 0,  0, 0, 9);

        // ---------------------------------------------------------------
        // Reset state
        // ---------------------------------------------------------------
        rst_n      = 1'b0;
        note_on    = 1'b0;
        note_off   = 1'b0;
        env_stb    = 1'b0;
        instrument = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_volume", -1, 8'(volume),    8'd0);
        check("reset_active", -1, 8'(active),    8'd0);
        check("reset_addr",   -1, 8'(inst_addr), 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // ---------------------------------------------------------------
        // Asynchronous reset in the middle of ATTACK at volume 7
        // ---------------------------------------------------------------
        step(mk(1, 0, 0, 3, 0, 1, 3));
        step(mk(0, 0, 1, 0, 0, 1, 3));
        for (int k = 1; k <= 7; k++) step(mk(0, 0, 1, 0, k, 1, 3));
        @(negedge clk);
        note_on  = 1'b0;
        note_off = 1'b0;
        env_stb  = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("async_reset_volume", -1, 8'(volume),    8'd0);
        check("async_reset_active", -1, 8'(active),    8'd0);
        check("async_reset_addr",   -1, 8'(inst_addr), 8'd0);
        env_stb = 1'b1;
        repeat (2) @(negedge clk);
        env_stb = 1'b0;
        rst_n   = 1'b1;
        repeat (3) step(mk(0, 0, 1, 0, 0, 0, 0));
        step(mk(0, 1, 0, 0, 0, 0, 0));
        step(mk(0, 0, 1, 0, 0, 0, 0));

        @(negedge clk);
        note_on  = 1'b0;
        note_off = 1'b0;
        env_stb  = 1'b0;
        @(negedge clk);
        check("scoreboard_drained", -1, 8'(sb_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
